// File: rtl/dct_transpose_pingpong_pkg.sv
// Shared constants and helpers for the 2-D DCT transpose buffer and its
// neighbouring column/row 1-D DCT stages.
package dct_transpose_pingpong_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_DATA_W = 11;
  localparam int DCT_BEAT_W = DCT_N * DCT_DATA_W;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_e;

  // Bit offset of element k inside a beat whose elements are w bits wide.
  function automatic int elem_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/dct_transpose_pingpong_bank.sv
// One N x N element bank: whole rows are written, and a row or a column is
// read back combinationally depending on the mode input.
module tpb_bank
  import dct_transpose_pingpong_pkg::*;
#(
  parameter int N      = DCT_N,
  parameter int DATA_W = DCT_DATA_W
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [$clog2(N)-1:0]    i_wrow,
  input  logic [N*DATA_W-1:0]     i_wdata,
  input  logic [$clog2(N)-1:0]    i_ridx,
  input  logic                    i_col_mode,
  output logic [N*DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] mem [N][N];

  // Store a full incoming row; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < N; k++) begin
        mem[i_wrow][k] <= i_wdata[elem_lsb(k, DATA_W) +: DATA_W];
      end
    end
  end

  // Column mode gathers element i_ridx of every row; row mode returns row i_ridx.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < N; k++) begin
      o_rdata[elem_lsb(k, DATA_W) +: DATA_W] = i_col_mode ? mem[k][i_ridx] : mem[i_ridx][k];
    end
  end

endmodule

// File: rtl/dct_transpose_pingpong.sv
// Ping-pong transpose buffer: one bank fills with rows while the other drains
// as columns (or rows, in bypass), with valid/ready on both sides.
module dct_transpose_pingpong
  import dct_transpose_pingpong_pkg::*;
#(
  parameter int N      = DCT_N,
  parameter int DATA_W = DCT_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_bypass,
  input  logic [N*DATA_W-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N*DATA_W-1:0] o_data,
  output logic                o_last
);

  localparam int                IDX_W  = $clog2(N);
  localparam int                BEAT_W = N * DATA_W;
  localparam logic [IDX_W-1:0]  LAST   = IDX_W'(N - 1);

  bank_sel_e          wsel;
  bank_sel_e          rsel;
  logic [IDX_W-1:0]   wrow;
  logic [IDX_W-1:0]   rcol;
  logic [1:0]         full;
  logic [1:0]         bypass;
  logic               wr_accept;
  logic               rd_accept;
  logic [1:0]         bank_we;
  logic [BEAT_W-1:0]  rdata_a;
  logic [BEAT_W-1:0]  rdata_b;

  assign o_ready   = !full[wsel];
  assign wr_accept = i_valid & o_ready;
  assign o_valid   = full[rsel];
  assign rd_accept = o_valid & i_ready;
  assign o_last    = o_valid & (rcol == LAST);
  assign o_data    = (rsel == BANK_B) ? rdata_b : rdata_a;

  // Route the accepted row to whichever bank is currently filling.
  always_comb begin
    bank_we    = '0;
    bank_we[0] = wr_accept & (wsel == BANK_A);
    bank_we[1] = wr_accept & (wsel == BANK_B);
  end

  tpb_bank #(.N(N), .DATA_W(DATA_W)) u_bank_a (
    .i_clk      (i_clk),
    .i_we       (bank_we[0]),
    .i_wrow     (wrow),
    .i_wdata    (i_data),
    .i_ridx     (rcol),
    .i_col_mode (!bypass[0]),
    .o_rdata    (rdata_a)
  );

  tpb_bank #(.N(N), .DATA_W(DATA_W)) u_bank_b (
    .i_clk      (i_clk),
    .i_we       (bank_we[1]),
    .i_wrow     (wrow),
    .i_wdata    (i_data),
    .i_ridx     (rcol),
    .i_col_mode (!bypass[1]),
    .o_rdata    (rdata_b)
  );

  // Write-side row counter; hands over to the other bank after the last row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrow <= '0;
      wsel <= BANK_A;
    end else if (wr_accept) begin
      if (wrow == LAST) begin
        wrow <= '0;
        wsel <= (wsel == BANK_A) ? BANK_B : BANK_A;
      end else begin
        wrow <= wrow + IDX_W'(1);
      end
    end
  end

  // Read-side column counter; releases the bank after its last beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rcol <= '0;
      rsel <= BANK_A;
    end else if (rd_accept) begin
      if (rcol == LAST) begin
        rcol <= '0;
        rsel <= (rsel == BANK_A) ? BANK_B : BANK_A;
      end else begin
        rcol <= rcol + IDX_W'(1);
      end
    end
  end

  // Per-bank flags; a fill and a drain always target different banks, so
  // both updates can land in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full   <= '0;
      bypass <= '0;
    end else begin
      if (wr_accept && (wrow == '0)) begin
        bypass[wsel] <= i_bypass;
      end
      if (wr_accept && (wrow == LAST)) begin
        full[wsel] <= 1'b1;
      end
      if (rd_accept && (rcol == LAST)) begin
        full[rsel] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_pingpong.sv
// Self-checking bench: table-driven directed vectors on an N=8 instance plus a
// randomised scoreboard run on an N=4, DATA_W=14 instance.
module tb_dct_transpose_pingpong;

  logic        clk = 1'b0;
  logic        rst;

  logic        v8, or8, byp8, rdy8, ov8, ol8;
  logic [87:0] d8, od8;

  logic        v4, or4, byp4, rdy4, ov4, ol4;
  logic [55:0] d4, od4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rst;
    logic v;
    logic byp;
    logic rdy;
    int   row_base;
    logic exp_ordy;
    logic exp_ovalid;
    logic exp_olast;
    int   exp_base;
    int   exp_stride;
  } vec_t;

  vec_t tbl[$];

  dct_transpose_pingpong #(.N(8), .DATA_W(11)) dut8 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (v8),
    .o_ready  (or8),
    .i_bypass (byp8),
    .i_data   (d8),
    .o_valid  (ov8),
    .i_ready  (rdy8),
    .o_data   (od8),
    .o_last   (ol8)
  );

  dct_transpose_pingpong #(.N(4), .DATA_W(14)) dut4 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (v4),
    .o_ready  (or4),
    .i_bypass (byp4),
    .i_data   (d4),
    .o_valid  (ov4),
    .i_ready  (rdy4),
    .o_data   (od4),
    .o_last   (ol4)
  );

  always #5 clk = ~clk;

  // Beat of eight 11-bit elements, element k = base + stride*k.
  function automatic logic [87:0] pat8(input int base, input int stride);
    logic [87:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[k*11 +: 11] = 11'(base + stride * k);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic rst_i, input logic v, input logic byp, input logic rdy,
                              input int row_base, input logic ordy, input logic ovalid,
                              input logic olast, input int ebase, input int estride);
    vec_t e;
    e.rst = rst_i; e.v = v; e.byp = byp; e.rdy = rdy; e.row_base = row_base;
    e.exp_ordy = ordy; e.exp_ovalid = ovalid; e.exp_olast = olast;
    e.exp_base = ebase; e.exp_stride = estride;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t e);
    rst  = e.rst;
    v8   = e.v;
    byp8 = e.byp;
    rdy8 = e.rdy;
    d8   = pat8(e.row_base, 1);
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      checkOutput($sformatf("%s[%0d].o_ready", tag, i), or8, tbl[i].exp_ordy);
      checkOutput($sformatf("%s[%0d].o_valid", tag, i), ov8, tbl[i].exp_ovalid);
      checkOutput($sformatf("%s[%0d].o_last", tag, i), ol8, tbl[i].exp_olast);
      if (tbl[i].exp_ovalid) begin
        checkOutput($sformatf("%s[%0d].o_data", tag, i), od8,
                    pat8(tbl[i].exp_base, tbl[i].exp_stride));
      end
    end
    tbl.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; v8 = 1'b0; rdy8 = 1'b0; v4 = 1'b0; rdy4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.o_valid", ov8, 1'b0);
    checkOutput("reset.o_ready", or8, 1'b1);
    checkOutput("reset.o_last", ol8, 1'b0);
    checkOutput("reset.n4_o_valid", ov4, 1'b0);
    checkOutput("reset.n4_o_ready", or4, 1'b1);
  endtask

  // Three back-to-back blocks: bypass block (odd rows toggle i_bypass), then
  // a transposed block with mid-block toggles, then a plain transposed block.
  task automatic buildStreamTable();
    int b, r, ob, ebase, estride;
    logic byp, ovalid;
    for (int t = 0; t < 33; t++) begin
      b = t / 8; r = t % 8; ob = (t - 8) / 8;
      if (b == 0)      byp = (r == 0) ? 1'b1 : (r % 2 == 1);
      else if (b == 1) byp = (r == 0) ? 1'b0 : (r % 2 == 1);
      else             byp = 1'b0;
      ovalid = (t >= 8) && (t < 32);
      if (ob == 0) begin ebase = 8 * r; estride = 1; end
      else         begin ebase = ob * 100 + r; estride = 8; end
      tbl.push_back(mk(1'b0, t < 24, byp, 1'b1, b * 100 + 8 * r,
                       1'b1, ovalid, ovalid && (r == 7), ebase, estride));
    end
  endtask

  // Fill both banks with the sink stalled, hold, then drain both blocks.
  task automatic buildBackpressureTable();
    int c;
    for (int t = 0; t < 16; t++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, (t / 8) * 300 + 8 * (t % 8),
                       1'b1, t >= 8, 1'b0, 0, 8));
    for (int t = 16; t < 19; t++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 777, 1'b0, 1'b1, 1'b0, 0, 8));
    for (int t = 19; t < 27; t++) begin
      c = t - 19;
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, c == 7, c, 8));
    end
    for (int t = 27; t < 29; t++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 300, 8));
    for (int t = 29; t < 37; t++) begin
      c = t - 29;
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, c == 7, 300 + c, 8));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 8));
  endtask

  // Full bank partly drained plus a partial block, then reset and a fresh block.
  task automatic buildResetTable();
    int c;
    for (int t = 0; t < 8; t++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8 * t, 1'b1, 1'b0, 1'b0, 0, 8));
    for (int t = 8; t < 11; t++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, t - 8, 8));
    for (int t = 11; t < 16; t++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 400 + 8 * (t - 11), 1'b1, 1'b1, 1'b0, 3, 8));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 3, 8));
    for (int t = 17; t < 25; t++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 500 + 8 * (t - 17), 1'b1, 1'b0, 1'b0, 0, 8));
    for (int t = 25; t < 33; t++) begin
      c = t - 25;
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, c == 7, 500 + c, 8));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 8));
  endtask

  // Random rows with random stalls on both sides, checked against a transpose scoreboard.
  task automatic runRandomN4();
    logic [55:0] rows4 [20];
    logic [55:0] expq[$];
    logic [55:0] col;
    logic [55:0] want;
    logic        acc_in, acc_out;
    int          in_cnt, out_cnt, blk;
    in_cnt = 0; out_cnt = 0;
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < 4; k++)
        rows4[i][k*14 +: 14] = 14'($urandom);
    byp4 = 1'b0;
    for (int cyc = 0; cyc < 3000 && out_cnt < 20; cyc++) begin
      @(negedge clk);
      v4   = (in_cnt < 20) && ($urandom_range(3) != 0);
      d4   = (in_cnt < 20) ? rows4[in_cnt] : '0;
      rdy4 = ($urandom_range(2) != 0);
      acc_in  = v4 && or4;
      acc_out = ov4 && rdy4;
      if (acc_out) begin
        if (expq.size() == 0) begin
          checkOutput("n4.unexpected_beat", 1'b1, 1'b0);
        end else begin
          want = expq.pop_front();
          checkOutput($sformatf("n4.beat%0d.o_data", out_cnt), od4, want);
          checkOutput($sformatf("n4.beat%0d.o_last", out_cnt), ol4, (out_cnt % 4) == 3);
        end
        out_cnt++;
      end
      if (acc_in) begin
        in_cnt++;
        if (in_cnt % 4 == 0) begin
          blk = in_cnt / 4 - 1;
          for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++)
              col[k*14 +: 14] = rows4[blk*4 + k][c*14 +: 14];
            expq.push_back(col);
          end
        end
      end
    end
    checkOutput("n4.beats_received", out_cnt, 20);
    checkOutput("n4.scoreboard_empty", expq.size(), 0);
    @(negedge clk);
    v4 = 1'b0; rdy4 = 1'b1;
    @(negedge clk);
    checkOutput("n4.idle_o_valid", ov4, 1'b0);
    checkOutput("n4.idle_o_ready", or4, 1'b1);
  endtask

  initial begin
    rst = 1'b1; v8 = 1'b0; byp8 = 1'b0; rdy8 = 1'b0; d8 = '0;
    v4 = 1'b0; byp4 = 1'b0; rdy4 = 1'b0; d4 = '0;

    doReset();
    buildStreamTable();
    runTable("stream");

    doReset();
    buildBackpressureTable();
    runTable("backpressure");

    doReset();
    buildResetTable();
    runTable("midreset");

    doReset();
    runRandomN4();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
